// File: rtl/latch_bank_wr_ctrl.sv
// Round-robin write sequencer for a latrsnq-style latch bank.
// Optional bulk preset path: LATCH_BANK_WR_CTRL_PRESET_EN.
module latch_bank_wr_ctrl #(
  parameter int NREQ      = 4,
  parameter int ROWS      = 8,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                          CLK,
  input  logic                          RN,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*$clog2(ROWS)-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  output logic [NREQ-1:0]               ack,
  input  logic                          clr_req,
  output logic                          clr_ack,
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
  input  logic                          set_req,
  output logic                          set_ack,
`endif
  output logic [WIDTH-1:0]              lat_d,
  output logic [ROWS-1:0]               lat_e,
  output logic                          lat_rn,
  output logic                          lat_setn,
  output logic                          busy
);

  localparam int AW = $clog2(ROWS);
  localparam int PW = $clog2(NREQ);
  localparam logic [3:0] CNT_S = 4'(SETUP_CYC - 1);
  localparam logic [3:0] CNT_O = 4'(OPEN_CYC - 1);
  localparam logic [3:0] CNT_H = 4'(HOLD_CYC - 1);

`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
  typedef enum logic [2:0] {
    IDLE, SETUP, OPEN, HOLD, CLEAR, DONE, PRESET
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, SETUP, OPEN, HOLD, CLEAR, DONE
  } state_t;
`endif

  typedef enum logic [1:0] {
    OP_WR, OP_CLR, OP_SET
  } op_t;

  state_t           state, nxt;
  op_t              op, op_n;
  logic [3:0]       cnt, cnt_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [PW-1:0]    gnt, gnt_n;
  logic [PW-1:0]    arb;
  logic             hit;
  logic [AW-1:0]    addr, addr_n;
  logic [WIDTH-1:0] data, data_n;

  logic [NREQ-1:0]  ack_n;
  logic             clr_ack_n;
  logic [WIDTH-1:0] lat_d_n;
  logic [ROWS-1:0]  lat_e_n;
  logic             lat_rn_n;
  logic             lat_setn_n;
  logic             busy_n;
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
  logic             set_ack_n;
`endif

  // first requester at or after ptr, wrapping
  always_comb begin
    arb = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!hit && req[j]) begin
        hit = 1'b1;
        arb = PW'(j);
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      op    <= OP_WR;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      addr  <= '0;
      data  <= '0;
    end else begin
      state <= nxt;
      op    <= op_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      addr  <= addr_n;
      data  <= data_n;
    end
  end

  always_comb begin
    nxt    = state;
    op_n   = op;
    cnt_n  = cnt;
    ptr_n  = ptr;
    gnt_n  = gnt;
    addr_n = addr;
    data_n = data;
    case (state)
      IDLE: begin
        if (clr_req) begin
          nxt   = CLEAR;
          op_n  = OP_CLR;
          cnt_n = CNT_O;
        end
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
        else if (set_req) begin
          nxt   = PRESET;
          op_n  = OP_SET;
          cnt_n = CNT_O;
        end
`endif
        else if (hit) begin
          nxt    = SETUP;
          op_n   = OP_WR;
          cnt_n  = CNT_S;
          gnt_n  = arb;
          addr_n = req_addr[int'(arb)*AW +: AW];
          data_n = req_data[int'(arb)*WIDTH +: WIDTH];
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          nxt   = OPEN;
          cnt_n = CNT_O;
        end else cnt_n = cnt - 4'd1;
      end
      OPEN: begin
        if (cnt == '0) begin
          nxt   = HOLD;
          cnt_n = CNT_H;
        end else cnt_n = cnt - 4'd1;
      end
      HOLD: begin
        if (cnt == '0) nxt = DONE;
        else cnt_n = cnt - 4'd1;
      end
      CLEAR: begin
        if (cnt == '0) nxt = DONE;
        else cnt_n = cnt - 4'd1;
      end
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
      PRESET: begin
        if (cnt == '0) nxt = DONE;
        else cnt_n = cnt - 4'd1;
      end
`endif
      DONE: begin
        nxt = IDLE;
        if (op == OP_WR)
          ptr_n = (gnt == PW'(NREQ - 1)) ? '0 : gnt + PW'(1);
      end
      default: nxt = IDLE;
    endcase
  end

  // outputs are a function of the next state, then registered
  always_comb begin
    ack_n      = '0;
    clr_ack_n  = 1'b0;
    lat_d_n    = '0;
    lat_e_n    = '0;
    lat_rn_n   = (nxt != CLEAR);
    lat_setn_n = 1'b1;
    busy_n     = (nxt != IDLE);
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
    set_ack_n  = 1'b0;
    lat_setn_n = (nxt != PRESET);
`endif
    if (nxt inside {SETUP, OPEN, HOLD})
      lat_d_n = data_n;
    if (nxt == OPEN)
      lat_e_n = ROWS'(1) << addr_n;
    unique case (1'b1)
      (nxt == DONE && op_n == OP_WR):
        ack_n = NREQ'(1) << gnt_n;
      (nxt == DONE && op_n == OP_CLR):
        clr_ack_n = 1'b1;
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
      (nxt == DONE && op_n == OP_SET):
        set_ack_n = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      ack      <= '0;
      clr_ack  <= 1'b0;
      lat_d    <= '0;
      lat_e    <= '0;
      lat_rn   <= 1'b0;
      lat_setn <= 1'b1;
      busy     <= 1'b0;
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
      set_ack  <= 1'b0;
`endif
    end else begin
      ack      <= ack_n;
      clr_ack  <= clr_ack_n;
      lat_d    <= lat_d_n;
      lat_e    <= lat_e_n;
      lat_rn   <= lat_rn_n;
      lat_setn <= lat_setn_n;
      busy     <= busy_n;
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
      set_ack  <= set_ack_n;
`endif
    end
  end

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Bench for latch_bank_wr_ctrl: default timing plus a 3/1/4 instance.
// Each operation is checked against a per-cycle window model.
module tb_latch_bank_wr_ctrl;

  localparam int OP_I = 0;
  localparam int OP_W = 1;
  localparam int OP_C = 2;
  localparam int OP_P = 3;
  localparam int OP_R = 4;

  logic        CLK;
  logic        RN;
  logic        sel;
  logic [3:0]  req;
  logic        clr_req;
  logic        set_req;
  logic [2:0]  addr_a [4];
  logic [7:0]  data_a [4];
  logic [11:0] req_addr;
  logic [31:0] req_data;

  logic [3:0] req0, req1;
  logic       clr0, clr1, set0, set1;
  logic [3:0] ack0, ack1;
  logic       ca0, ca1, sa0, sa1;
  logic [7:0] ld0, ld1, le0, le1;
  logic       rn0, rn1, sn0, sn1, bz0, bz1;
  logic [25:0] obs;

  int n_chk = 0;
  int n_fail = 0;
  int m_ptr [2];
  int op_no = 0;

  assign req_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign req_data = {data_a[3], data_a[2], data_a[1], data_a[0]};
  assign req0 = sel ? 4'd0 : req;
  assign req1 = sel ? req : 4'd0;
  assign clr0 = sel ? 1'b0 : clr_req;
  assign clr1 = sel ? clr_req : 1'b0;
  assign set0 = sel ? 1'b0 : set_req;
  assign set1 = sel ? set_req : 1'b0;
  assign obs = sel ? {sa1, ack1, ca1, ld1, le1, rn1, sn1, bz1}
                   : {sa0, ack0, ca0, ld0, le0, rn0, sn0, bz0};

`ifndef LATCH_BANK_WR_CTRL_PRESET_EN
  assign sa0 = 1'b0;
  assign sa1 = 1'b0;
`endif

  latch_bank_wr_ctrl u0 (
    .CLK(CLK), .RN(RN),
    .req(req0), .req_addr(req_addr), .req_data(req_data),
    .ack(ack0), .clr_req(clr0), .clr_ack(ca0),
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
    .set_req(set0), .set_ack(sa0),
`endif
    .lat_d(ld0), .lat_e(le0), .lat_rn(rn0),
    .lat_setn(sn0), .busy(bz0)
  );

  latch_bank_wr_ctrl #(
    .SETUP_CYC(3), .OPEN_CYC(1), .HOLD_CYC(4)
  ) u1 (
    .CLK(CLK), .RN(RN),
    .req(req1), .req_addr(req_addr), .req_data(req_data),
    .ack(ack1), .clr_req(clr1), .clr_ack(ca1),
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
    .set_req(set1), .set_ack(sa1),
`endif
    .lat_d(ld1), .lat_e(le1), .lat_rn(rn1),
    .lat_setn(sn1), .busy(bz1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // expected outputs t cycles after an operation was taken
  function automatic logic [25:0] exp_vec(
    input int op, input int t, input int g, input int a,
    input logic [7:0] d, input int s, input int o, input int h);
    logic [3:0] ak;
    logic       ca, sa, rn, sn, bz;
    logic [7:0] ld, le;
    int l;
    ak = '0; ca = 0; sa = 0; ld = '0; le = '0;
    rn = 1; sn = 1; bz = 1;
    l = s + o + h + 1;
    if (op == OP_W) begin
      if (t < l) ld = d;
      if (t > s && t <= s + o) le = 8'd1 << a;
      if (t == l) ak = 4'd1 << g;
    end else if (op == OP_C) begin
      if (t <= o) rn = 0; else ca = 1;
    end else if (op == OP_P) begin
      if (t <= o) sn = 0; else sa = 1;
    end else if (op == OP_R) begin
      rn = 0; bz = 0;
    end else bz = 0;
    return {sa, ak, ca, ld, le, rn, sn, bz};
  endfunction

  task automatic chk(input string tag,
                     input logic [25:0] o,
                     input logic [25:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  // one arbitration decision and the whole resulting operation
  task automatic do_op(input bit drop, input bit mid_clr);
    int op, g, a, s, o, h, l, p;
    bit found;
    logic [7:0] d;
    s = sel ? 3 : 1;
    o = sel ? 1 : 2;
    h = sel ? 4 : 1;
    p = sel ? 1 : 0;
    g = 0; a = 0; d = '0; found = 0;
    op_no++;
    if (clr_req) op = OP_C;
`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
    else if (set_req) op = OP_P;
`endif
    else if (|req) begin
      op = OP_W;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr[p] + k) % 4;
        if (!found && req[j]) begin
          found = 1;
          g = j;
        end
      end
      a = int'(addr_a[g]);
      d = data_a[g];
    end else op = OP_I;
    l = (op == OP_W) ? s + o + h + 1 :
        (op == OP_I) ? 0 : o + 1;
    for (int t = 1; t <= l; t++) begin
      @(negedge CLK);
      chk($sformatf("op%0d t%0d", op_no, t), obs,
          exp_vec(op, t, g, a, d, s, o, h));
      if (t == 1 && mid_clr) clr_req = 1'b1;
    end
    if (op == OP_W) begin
      m_ptr[p] = (g + 1) % 4;
      if (drop) req[g] = 1'b0;
    end
    if (op == OP_C) clr_req = 1'b0;
    if (op == OP_P) set_req = 1'b0;
    @(negedge CLK);
    chk($sformatf("op%0d idle", op_no), obs,
        exp_vec(OP_I, 0, 0, 0, 8'd0, s, o, h));
  endtask

  initial begin
    RN = 1'b0; sel = 1'b0; req = '0;
    clr_req = 1'b0; set_req = 1'b0;
    m_ptr[0] = 0; m_ptr[1] = 0;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = '0;
      data_a[i] = '0;
    end

    #12;
    chk("reset", obs, exp_vec(OP_R, 0, 0, 0, 8'd0, 1, 2, 1));
    @(negedge CLK);
    RN = 1'b1;
    #1;
    chk("rn_hold", obs, exp_vec(OP_R, 0, 0, 0, 8'd0, 1, 2, 1));
    @(negedge CLK);
    chk("rn_rel", obs, exp_vec(OP_I, 0, 0, 0, 8'd0, 1, 2, 1));

    // single write from requester 1
    addr_a[1] = 3'd5; data_a[1] = 8'hA5; req = 4'b0010;
    do_op(1, 0);

    // reset while row 2 is open
    addr_a[2] = 3'd2; data_a[2] = 8'($urandom); req = 4'b0100;
    @(negedge CLK);
    chk("pre_rst_t1", obs,
        exp_vec(OP_W, 1, 2, 2, data_a[2], 1, 2, 1));
    @(negedge CLK);
    chk("pre_rst_open", obs,
        exp_vec(OP_W, 2, 2, 2, data_a[2], 1, 2, 1));
    #2;
    RN = 1'b0; req = '0;
    #1;
    chk("async_rst", obs, exp_vec(OP_R, 0, 0, 0, 8'd0, 1, 2, 1));
    m_ptr[0] = 0;
    RN = 1'b1;
    #1;
    chk("rn_low_til_edge", obs,
        exp_vec(OP_R, 0, 0, 0, 8'd0, 1, 2, 1));
    @(posedge CLK);
    #1;
    chk("rn_after_edge", obs,
        exp_vec(OP_I, 0, 0, 0, 8'd0, 1, 2, 1));
    @(negedge CLK);
    addr_a[0] = 3'($urandom); data_a[0] = 8'($urandom);
    addr_a[3] = 3'($urandom); data_a[3] = 8'($urandom);
    req = 4'b1001;
    do_op(1, 0);

    // clear raised during requester 2's setup, requester 3 pending
    addr_a[2] = 3'($urandom); data_a[2] = 8'($urandom);
    req = 4'b1100;
    do_op(1, 1);
    do_op(1, 0);
    do_op(1, 0);

    // all requesters active
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 3'(i);
      data_a[i] = 8'($urandom);
    end
    req = 4'hF;
    for (int n = 0; n < 5; n++) do_op(0, 0);
    req = '0;

    // random traffic
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          addr_a[i] = 3'($urandom);
          data_a[i] = 8'($urandom);
        end
      if ($urandom_range(0, 7) == 0) clr_req = 1'b1;
      do_op(1, $urandom_range(0, 9) == 0);
    end
    for (int n = 0; n < 8; n++)
      if (|req || clr_req) do_op(1, 0);

    // slow-timing instance
    req = '0; clr_req = 1'b0;
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 3'($urandom);
      data_a[i] = 8'($urandom);
    end
    req = 4'b0110;
    do_op(1, 0);
    clr_req = 1'b1;
    do_op(1, 0);
    do_op(1, 0);
    sel = 1'b0;

`ifdef LATCH_BANK_WR_CTRL_PRESET_EN
    clr_req = 1'b1; set_req = 1'b1;
    do_op(1, 0);
    do_op(1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
